// File: rtl/ddr_resp_pkg.sv
// ddr_resp_pkg: shared opcodes, error codes, timing defaults and read-beat type for ddr_cmd_responder
package ddr_resp_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_ACT, OP_RD, OP_WR, OP_PRE, OP_REF} op_e;
  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
  localparam logic [2:0] ERR_RCD         = 3'd3;
  localparam logic [2:0] ERR_RAS         = 3'd4;
  localparam logic [2:0] ERR_ACT_TIMING  = 3'd5;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd6;
  localparam int DEF_T_RCD = 3;
  localparam int DEF_T_RP  = 3;
  localparam int DEF_T_RAS = 6;
  localparam int DEF_T_RFC = 10;
  localparam int DEF_T_WR  = 3;
  localparam int DEF_T_WTR = 2;
  localparam int DEF_T_RTP = 2;
  localparam int DEF_CL    = 3;
  localparam int CNT_W     = 8;
  localparam int TM_RCD = 0;
  localparam int TM_RP  = 1;
  localparam int TM_RAS = 2;
  localparam int TM_RFC = 3;
  localparam int TM_WR  = 4;
  localparam int TM_WTR = 5;
  localparam int TM_RTP = 6;
  localparam int TM_N   = 7;
  typedef struct packed {
    logic       v;
    logic [2:0] ba;
    logic [9:0] col;
  } rd_beat_t;
  function automatic op_e decode(input logic ras_n, input logic cas_n, input logic we_n);
    case ({ras_n, cas_n, we_n})
      3'b011:  return OP_ACT;
      3'b101:  return OP_RD;
      3'b100:  return OP_WR;
      3'b010:  return OP_PRE;
      3'b001:  return OP_REF;
      default: return OP_NOP;
    endcase
  endfunction
endpackage

// File: rtl/ddr_cmd_responder_timer.sv
// ddr_timer: loads load on start, counts down to 0 and saturates; done is low in the start cycle
module ddr_timer
  import ddr_resp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] load,
  input  logic             start,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = start ? load : (cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1));
  end
  always_ff @(posedge clk) begin
    cnt_q <= !reset ? '0 : cnt_d;
  end
  assign cnt  = cnt_q;
  assign done = cnt_q == '0 && !start;
endmodule

// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder: DDR command decoder with bank/timer tracking and CL read beats; DDR_RESP_ERRCHK_EN adds protocol checks
module ddr_cmd_responder
  import ddr_resp_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RFC = DEF_T_RFC,
  parameter int T_WR  = DEF_T_WR,
  parameter int T_WTR = DEF_T_WTR,
  parameter int T_RTP = DEF_T_RTP,
  parameter int CL    = DEF_CL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [13:0] addr,
  input  logic [2:0]  ba,
  input  logic        cmd_valid,
  output logic        tRCD_done,
  output logic        tRP_done,
  output logic        tRAS_done,
  output logic        tRFC_done,
  output logic        tWR_done,
  output logic        tWTR_done,
  output logic        tRTP_done,
  output logic [7:0]  bank_open,
  output logic        rd_valid,
  output logic [2:0]  rd_bank,
  output logic [9:0]  rd_col,
  output logic        err_valid,
  output logic [2:0]  err_code
);
  op_e                          op, hist_op_d, hist_op_q;
  logic [2:0]                   hist_ba_d, hist_ba_q;
  logic [13:0]                  hist_addr_d, hist_addr_q;
  logic                         is_new, c_act, c_rd, c_wr, c_pre, c_ref, row_ld;
  logic [TM_N-1:0]              start, done;
  logic [TM_N-1:0][CNT_W-1:0]   load, cnt;
  logic [7:0]                   bank_open_d, bank_open_q;
  logic [7:0][13:0]             row_d, row_q;
  rd_beat_t [CL-1:0]            rd_pipe_d, rd_pipe_q;
  assign load = {CNT_W'(T_RTP - 1), CNT_W'(T_WTR - 1), CNT_W'(T_WR - 1), CNT_W'(T_RFC - 1),
                 CNT_W'(T_RAS - 1), CNT_W'(T_RP - 1), CNT_W'(T_RCD - 1)};
  for (genvar i = 0; i < TM_N; i++) begin : g_tm
    ddr_timer u_tm (
      .clk  (clk),
      .reset(reset),
      .load (load[i]),
      .start(start[i]),
      .cnt  (cnt[i]),
      .done (done[i])
    );
  end
  always_comb begin
    op          = reset && cmd_valid && !cs_n ? decode(ras_n, cas_n, we_n) : OP_NOP;
    is_new      = op != OP_NOP && !(op == hist_op_q && ba == hist_ba_q && addr == hist_addr_q);
    c_act       = is_new && op == OP_ACT;
    c_rd        = is_new && op == OP_RD;
    c_wr        = is_new && op == OP_WR;
    c_pre       = is_new && op == OP_PRE;
    c_ref       = is_new && op == OP_REF;
    start       = {c_rd, c_wr, c_wr, c_ref, c_act, c_pre, c_act};
    hist_op_d   = op;
    hist_ba_d   = ba;
    hist_addr_d = addr;
    bank_open_d = c_pre ? (addr[10] ? 8'h00 : bank_open_q & ~(8'b1 << ba))
                : c_act ? bank_open_q | (8'b1 << ba) : bank_open_q;
    row_d       = row_q;
    if (c_act && row_ld) row_d[ba] = addr;
    rd_pipe_d[0] = c_rd ? {1'b1, ba, addr[9:0]} : '0;
    for (int k = 1; k < CL; k++) rd_pipe_d[k] = rd_pipe_q[k-1];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_op_q   <= OP_NOP;
      hist_ba_q   <= '0;
      hist_addr_q <= '0;
      bank_open_q <= '0;
      row_q       <= '0;
      rd_pipe_q   <= '0;
    end else begin
      hist_op_q   <= hist_op_d;
      hist_ba_q   <= hist_ba_d;
      hist_addr_q <= hist_addr_d;
      bank_open_q <= bank_open_d;
      row_q       <= row_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end
`ifdef DDR_RESP_ERRCHK_EN
  logic [2:0] err_d, err_code_d, err_code_q;
  logic       err_valid_d, err_valid_q;
  always_comb begin
    err_d       = c_act ? (bank_open_q[ba] ? ERR_ACT_OPEN
                           : !(done[TM_RP] && done[TM_RFC]) ? ERR_ACT_TIMING : ERR_NONE)
                : (c_rd || c_wr) ? (!bank_open_q[ba] ? ERR_BANK_CLOSED
                           : !done[TM_RCD] ? ERR_RCD : ERR_NONE)
                : c_pre ? (!done[TM_RAS] ? ERR_RAS : ERR_NONE)
                : (c_ref && |bank_open_q) ? ERR_REF_OPEN : ERR_NONE;
    err_valid_d = err_d != ERR_NONE;
    err_code_d  = err_code_q == ERR_NONE ? err_d : err_code_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end
  assign row_ld    = !bank_open_q[ba];
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
`else
  assign row_ld    = 1'b1;
  assign err_valid = 1'b0;
  assign err_code  = ERR_NONE;
`endif
  assign tRCD_done = done[TM_RCD];
  assign tRP_done  = done[TM_RP];
  assign tRAS_done = done[TM_RAS];
  assign tRFC_done = done[TM_RFC];
  assign tWR_done  = done[TM_WR];
  assign tWTR_done = done[TM_WTR];
  assign tRTP_done = done[TM_RTP];
  assign bank_open = bank_open_q;
  assign rd_valid  = rd_pipe_q[CL-1].v;
  assign rd_bank   = rd_pipe_q[CL-1].ba;
  assign rd_col    = rd_pipe_q[CL-1].col;
endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb_ddr_cmd_responder: directed vectors with hand-computed expectations for ddr_cmd_responder
module tb_ddr_cmd_responder;
  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001, NOPC = 3'b111;
`ifdef DDR_RESP_ERRCHK_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cmd_valid = 1'b0;
  logic [13:0] addr = '0;
  logic [2:0]  ba = '0;
  logic        tRCD_done, tRP_done, tRAS_done, tRFC_done, tWR_done, tWTR_done, tRTP_done;
  logic [7:0]  bank_open;
  logic        rd_valid, err_valid;
  logic [2:0]  rd_bank, err_code;
  logic [9:0]  rd_col;
  int          checks = 0, errors = 0;
  wire  [6:0]  dn = {tRCD_done, tRP_done, tRAS_done, tRFC_done, tWR_done, tWTR_done, tRTP_done};
  ddr_cmd_responder dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .addr(addr), .ba(ba), .cmd_valid(cmd_valid),
    .tRCD_done(tRCD_done), .tRP_done(tRP_done), .tRAS_done(tRAS_done), .tRFC_done(tRFC_done),
    .tWR_done(tWR_done), .tWTR_done(tWTR_done), .tRTP_done(tRTP_done),
    .bank_open(bank_open), .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_col(rd_col),
    .err_valid(err_valid), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [2:0] c, input logic [2:0] b, input logic [13:0] a);
    @(posedge clk);
    #2;
    cmd_valid = v;
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    #1;
  endtask
  task automatic nop(input int n);
    repeat (n) cyc(1'b0, NOPC, 3'd0, 14'd0);
  endtask
  initial begin
    nop(2);
    chk("rst_done", 32'(dn), 32'h7F);
    chk("rst_bank_open", 32'(bank_open), 0);
    chk("rst_rd", 32'({rd_valid, rd_bank, rd_col}), 0);
    chk("rst_err", 32'({err_valid, err_code}), 0);
    reset = 1'b1;
    cyc(1, ACT, 3'd2, 14'h1A5);
    chk("act_rcd_c0", 32'(tRCD_done), 0);
    chk("act_ras_c0", 32'(tRAS_done), 0);
    cyc(1, ACT, 3'd2, 14'h1A5);
    chk("act_rcd_c1", 32'(tRCD_done), 0);
    cyc(1, ACT, 3'd2, 14'h1A5);
    chk("act_rcd_c2", 32'(tRCD_done), 0);
    chk("act_bank_open", 32'(bank_open), 32'h04);
    cyc(1, RD, 3'd2, 14'h03C);
    chk("rd_rcd_c3", 32'(tRCD_done), 1);
    chk("rd_rtp_start", 32'(tRTP_done), 0);
    nop(1);
    chk("rd_rtp_c1", 32'(tRTP_done), 0);
    chk("rd_no_early_beat", 32'(rd_valid), 0);
    nop(1);
    chk("rd_rtp_c2", 32'(tRTP_done), 1);
    chk("rd_no_beat_cl1", 32'(rd_valid), 0);
    nop(1);
    chk("rd_beat", 32'({rd_valid, rd_bank, rd_col}), 32'({1'b1, 3'd2, 10'h03C}));
    cyc(1, RD, 3'd2, 14'h001);
    chk("rd_beat_one_wide", 32'(rd_valid), 0);
    cyc(1, RD, 3'd2, 14'h002);
    nop(2);
    chk("b2b_beat1", 32'({rd_valid, rd_bank, rd_col}), 32'({1'b1, 3'd2, 10'h001}));
    nop(1);
    chk("b2b_beat2", 32'({rd_valid, rd_bank, rd_col}), 32'({1'b1, 3'd2, 10'h002}));
    cyc(1, RD, 3'd2, 14'h005);
    chk("b2b_end", 32'(rd_valid), 0);
    cyc(1, RD, 3'd2, 14'h005);
    nop(2);
    chk("held_rd_beat", 32'({rd_valid, rd_col}), 32'({1'b1, 10'h005}));
    nop(1);
    chk("held_rd_single", 32'(rd_valid), 0);
    cyc(1, PRE, 3'd2, 14'h000);
    chk("pre_rp_start", 32'(tRP_done), 0);
    nop(1);
    chk("pre_bank_closed", 32'(bank_open), 0);
    chk("pre_no_err", 32'({err_valid, err_code}), 0);
    nop(4);
    cyc(1, ACT, 3'd0, 14'h010);
    nop(3);
    cyc(1, WR, 3'd0, 14'h020);
    chk("wr_c0", 32'({tWR_done, tWTR_done}), 0);
    cyc(1, WR, 3'd0, 14'h020);
    chk("wr_c1", 32'({tWR_done, tWTR_done}), 0);
    cyc(1, WR, 3'd0, 14'h020);
    chk("wr_c2", 32'({tWR_done, tWTR_done}), 32'b01);
    nop(1);
    chk("wr_c3", 32'({tWR_done, tWTR_done}), 32'b11);
    chk("wr_no_err", 32'({err_valid, err_code}), 0);
    nop(2);
    cyc(1, ACT, 3'd1, 14'h001);
    cyc(1, ACT, 3'd5, 14'h002);
    nop(1);
    chk("banks_1_5_0", 32'(bank_open), 32'h23);
    nop(6);
    cyc(1, PRE, 3'd0, 14'h400);
    nop(1);
    chk("pre_all", 32'(bank_open), 0);
    nop(3);
    cyc(1, REF, 3'd0, 14'h000);
    chk("ref_start", 32'(tRFC_done), 0);
    repeat (8) cyc(1, REF, 3'd0, 14'h000);
    cyc(1, REF, 3'd0, 14'h000);
    chk("ref_c9", 32'(tRFC_done), 0);
    cyc(1, REF, 3'd0, 14'h000);
    chk("ref_c10", 32'(tRFC_done), 1);
    nop(1);
    chk("ref_no_err", 32'({err_valid, err_code}), 0);
    nop(2);
    cyc(1, ACT, 3'd3, 14'h033);
    nop(1);
    cyc(1, PRE, 3'd3, 14'h000);
    chk("early_pre_ras", 32'(tRAS_done), 0);
    nop(1);
    chk("early_pre_err", 32'({err_valid, err_code}), EC ? 32'({1'b1, 3'd4}) : 0);
    chk("early_pre_closed", 32'(bank_open[3]), 0);
    nop(1);
    chk("err_pulse_end", 32'({err_valid, err_code}), EC ? 32'({1'b0, 3'd4}) : 0);
    nop(3);
    cyc(1, ACT, 3'd3, 14'h040);
    cyc(1, ACT, 3'd3, 14'h041);
    nop(1);
    chk("act_open_err", 32'({err_valid, err_code}), EC ? 32'({1'b1, 3'd4}) : 0);
    chk("act_open_bank", 32'(bank_open[3]), 1);
    nop(2);
    cyc(1, RD, 3'd3, 14'h007);
    cyc(1'b0, NOPC, 3'd0, 14'd0);
    reset = 1'b0;
    cyc(1'b0, NOPC, 3'd0, 14'd0);
    chk("midrst_done", 32'(dn), 32'h7F);
    chk("midrst_bank_open", 32'(bank_open), 0);
    chk("midrst_rd", 32'(rd_valid), 0);
    chk("midrst_err", 32'({err_valid, err_code}), 0);
    reset = 1'b1;
    nop(1);
    chk("midrst_no_beat", 32'(rd_valid), 0);
    nop(1);
    chk("midrst_no_beat2", 32'(rd_valid), 0);
    cyc(1, RD, 3'd4, 14'h009);
    nop(1);
    chk("rd_closed_err", 32'({err_valid, err_code}), EC ? 32'({1'b1, 3'd2}) : 0);
    nop(2);
    chk("rd_closed_beat", 32'({rd_valid, rd_bank, rd_col}), 32'({1'b1, 3'd4, 10'h009}));
    nop(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
